// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the BRAM port arbiter
// Contents: requester owner encoding, read-tag struct, read latency and
// hold-counter width.
package bram_arb_pkg;

  typedef enum logic {
    OWNER_REQ0 = 1'b0,
    OWNER_REQ1 = 1'b1
  } owner_e;

  // Travels alongside each accepted read so its data returns to the right requester.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Accept -> BRAM command (1) -> BRAM data (1) -> response register (1).
  localparam int READ_LATENCY = 3;

  // Wide enough for the full legal range of C_MAX_HOLD (1..15).
  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/bram_arb_rdpipe.sv
// rtl/bram_arb_rdpipe.sv - read-tag pipeline and per-requester read response registers
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_tag                   : tag of the command accepted this cycle (valid = read)
//   i_bram_din              : BRAM read data, valid one cycle after the BRAM command
//   o_rvalid0/1, o_rdata0/1 : per-requester read response; rdata holds between pulses
module bram_arb_rdpipe
  import bram_arb_pkg::*;
#(
  parameter int C_PORT_DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  rd_tag_t                  i_tag,
  input  logic [C_PORT_DWIDTH-1:0] i_bram_din,
  output logic                     o_rvalid0,
  output logic [C_PORT_DWIDTH-1:0] o_rdata0,
  output logic                     o_rvalid1,
  output logic [C_PORT_DWIDTH-1:0] o_rdata1
);

  // The response register supplies the last cycle of latency, so the tag
  // only needs to cover the stages before it.
  localparam int LP_STAGES = READ_LATENCY - 1;

  rd_tag_t                  r_tag [LP_STAGES];
  logic                     r_rvalid0;
  logic                     r_rvalid1;
  logic [C_PORT_DWIDTH-1:0] r_rdata0;
  logic [C_PORT_DWIDTH-1:0] r_rdata1;

  logic w_ret0;
  logic w_ret1;

  // The last tag stage lines up with the cycle in which BRAM_Din is valid.
  assign w_ret0 = r_tag[LP_STAGES-1].valid && (r_tag[LP_STAGES-1].owner == OWNER_REQ0);
  assign w_ret1 = r_tag[LP_STAGES-1].valid && (r_tag[LP_STAGES-1].owner == OWNER_REQ1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LP_STAGES; i++) begin
        r_tag[i] <= '0;
      end
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < LP_STAGES; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_rvalid0 <= w_ret0;
      r_rvalid1 <= w_ret1;
      if (w_ret0) begin
        r_rdata0 <= i_bram_din;
      end
      if (w_ret1) begin
        r_rdata1 <= i_bram_din;
      end
    end
  end

  assign o_rvalid0 = r_rvalid0;
  assign o_rdata0  = r_rdata0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata1  = r_rdata1;

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter for one BRAM port with pipelined commands
// Optional build macro: BRAM_ARB_ROUND_ROBIN_EN (round-robin on contention instead of
// fixed priority with the C_MAX_HOLD starvation guard).
// Ports:
//   BRAM_Clk, BRAM_Rst_N          : clock, asynchronous active-low reset
//   Req0_* (high priority), Req1_* : Valid/Ready command handshake with WE/Addr/WData,
//                                    RValid/RData read response (3 cycles after accept)
//   BRAM_EN/WEN/Addr/Dout          : registered BRAM command, one cycle after accept
//   BRAM_Din                       : BRAM read data (1-cycle read latency)
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_MAX_HOLD    = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,

  input  logic                     Req0_Valid,
  output logic                     Req0_Ready,
  input  logic [C_NUM_WE-1:0]      Req0_WE,
  input  logic [C_PORT_AWIDTH-1:0] Req0_Addr,
  input  logic [C_PORT_DWIDTH-1:0] Req0_WData,
  output logic                     Req0_RValid,
  output logic [C_PORT_DWIDTH-1:0] Req0_RData,

  input  logic                     Req1_Valid,
  output logic                     Req1_Ready,
  input  logic [C_NUM_WE-1:0]      Req1_WE,
  input  logic [C_PORT_AWIDTH-1:0] Req1_Addr,
  input  logic [C_PORT_DWIDTH-1:0] Req1_WData,
  output logic                     Req1_RValid,
  output logic [C_PORT_DWIDTH-1:0] Req1_RData,

  output logic                     BRAM_EN,
  output logic [C_NUM_WE-1:0]      BRAM_WEN,
  output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Din
);

  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_acc0;
  logic                     w_acc1;
  logic                     w_accept;
  logic [C_NUM_WE-1:0]      w_win_we;
  logic [C_PORT_AWIDTH-1:0] w_win_addr;
  logic [C_PORT_DWIDTH-1:0] w_win_wdata;
  owner_e                   w_win_owner;
  rd_tag_t                  w_rd_tag;

  logic                     r_bram_en;
  logic [C_NUM_WE-1:0]      r_bram_wen;
  logic [C_PORT_AWIDTH-1:0] r_bram_addr;
  logic [C_PORT_DWIDTH-1:0] r_bram_dout;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  owner_e r_last_grant;
`else
  localparam logic [HOLD_CNT_W-1:0] LP_MAX_HOLD = HOLD_CNT_W'(C_MAX_HOLD);
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
`endif

  // Arbitration: a grant is only ever given to a requester that is valid,
  // so a grant is also an accept once reset is released.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      if (r_last_grant == OWNER_REQ0) begin
        w_grant1 = 1'b1;
      end else begin
        w_grant0 = 1'b1;
      end
`else
      if (r_hold_cnt == LP_MAX_HOLD) begin
        w_grant1 = 1'b1;
      end else begin
        w_grant0 = 1'b1;
      end
`endif
    end else if (Req0_Valid) begin
      w_grant0 = 1'b1;
    end else if (Req1_Valid) begin
      w_grant1 = 1'b1;
    end
  end

  // Ready is gated by reset so nothing can be accepted while the pipeline is held.
  assign Req0_Ready = w_grant0 & BRAM_Rst_N;
  assign Req1_Ready = w_grant1 & BRAM_Rst_N;

  assign w_acc0   = Req0_Valid & Req0_Ready;
  assign w_acc1   = Req1_Valid & Req1_Ready;
  assign w_accept = w_acc0 | w_acc1;

  always_comb begin
    w_win_we    = Req0_WE;
    w_win_addr  = Req0_Addr;
    w_win_wdata = Req0_WData;
    w_win_owner = OWNER_REQ0;
    if (w_acc1) begin
      w_win_we    = Req1_WE;
      w_win_addr  = Req1_Addr;
      w_win_wdata = Req1_WData;
      w_win_owner = OWNER_REQ1;
    end
  end

  // A command with no byte enables is a read and needs a response slot.
  always_comb begin
    w_rd_tag.valid = w_accept && (w_win_we == '0);
    w_rd_tag.owner = w_win_owner;
  end

  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_bram_en   <= 1'b0;
      r_bram_wen  <= '0;
      r_bram_addr <= '0;
      r_bram_dout <= '0;
    end else begin
      r_bram_en <= w_accept;
      if (w_accept) begin
        r_bram_wen  <= w_win_we;
        r_bram_addr <= w_win_addr;
        r_bram_dout <= w_win_wdata;
      end else begin
        // Idle cycle: EN/WEN drop, address and data keep their last values.
        r_bram_wen  <= '0;
      end
    end
  end

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_last_grant <= OWNER_REQ1;
    end else if (w_accept) begin
      r_last_grant <= w_win_owner;
    end
  end
`else
  // Counts consecutive wins of requester 0 while requester 1 is waiting;
  // reaching C_MAX_HOLD hands the next contended slot to requester 1.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_hold_cnt <= '0;
    end else if (w_acc1 || !Req1_Valid) begin
      r_hold_cnt <= '0;
    end else if (w_acc0 && (r_hold_cnt != LP_MAX_HOLD)) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`endif

  bram_arb_rdpipe #(
    .C_PORT_DWIDTH (C_PORT_DWIDTH)
  ) u_rdpipe (
    .clk        (BRAM_Clk),
    .rst_n      (BRAM_Rst_N),
    .i_tag      (w_rd_tag),
    .i_bram_din (BRAM_Din),
    .o_rvalid0  (Req0_RValid),
    .o_rdata0   (Req0_RData),
    .o_rvalid1  (Req1_RValid),
    .o_rdata1   (Req1_RData)
  );

  assign BRAM_EN   = r_bram_en;
  assign BRAM_WEN  = r_bram_wen;
  assign BRAM_Addr = r_bram_addr;
  assign BRAM_Dout = r_bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int NWE      = 4;
  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic           req0_valid = 1'b0, req0_ready;
  logic [NWE-1:0] req0_we    = '0;
  logic [AW-1:0]  req0_addr  = '0;
  logic [DW-1:0]  req0_wdata = '0;
  logic           req0_rvalid;
  logic [DW-1:0]  req0_rdata;
  logic           req1_valid = 1'b0, req1_ready;
  logic [NWE-1:0] req1_we    = '0;
  logic [AW-1:0]  req1_addr  = '0;
  logic [DW-1:0]  req1_wdata = '0;
  logic           req1_rvalid;
  logic [DW-1:0]  req1_rdata;
  logic           bram_en;
  logic [NWE-1:0] bram_wen;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_dout;
  logic [DW-1:0]  bram_din = '0;

  bram_port_arbiter #(
    .C_PORT_AWIDTH (AW),
    .C_PORT_DWIDTH (DW),
    .C_NUM_WE      (NWE),
    .C_MAX_HOLD    (MAX_HOLD)
  ) dut (
    .BRAM_Clk    (clk),
    .BRAM_Rst_N  (rst_n),
    .Req0_Valid  (req0_valid),
    .Req0_Ready  (req0_ready),
    .Req0_WE     (req0_we),
    .Req0_Addr   (req0_addr),
    .Req0_WData  (req0_wdata),
    .Req0_RValid (req0_rvalid),
    .Req0_RData  (req0_rdata),
    .Req1_Valid  (req1_valid),
    .Req1_Ready  (req1_ready),
    .Req1_WE     (req1_we),
    .Req1_Addr   (req1_addr),
    .Req1_WData  (req1_wdata),
    .Req1_RValid (req1_rvalid),
    .Req1_RData  (req1_rdata),
    .BRAM_EN     (bram_en),
    .BRAM_WEN    (bram_wen),
    .BRAM_Addr   (bram_addr),
    .BRAM_Dout   (bram_dout),
    .BRAM_Din    (bram_din)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Environment BRAM: 16 words, write-first, one cycle read latency.
  logic [DW-1:0] bram_mem [16];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < NWE; b++) begin
        if (bram_wen[b]) bram_mem[bram_addr[5:2]][b*8 +: 8] = bram_dout[b*8 +: 8];
      end
      bram_din <= bram_mem[bram_addr[5:2]];
    end
  end

  // Requester command queues; vld=0 entries are one-cycle bubbles.
  typedef struct {
    bit             vld;
    logic [NWE-1:0] we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
  } cmd_t;

  typedef struct {
    int            due;
    bit            owner;
    logic [DW-1:0] data;
  } resp_t;

  cmd_t  q0[$], q1[$];
  resp_t resp_q[$];
  bit    shown0 = 0, shown1 = 0;
  bit    acc0 = 0, acc1 = 0;
  bit    rec_en = 0;
  bit    gseq[$];
  int    rv0_cnt = 0, rv1_cnt = 0;

  // Reference model state
  logic [DW-1:0]  ref_mem [16];
  logic           exp_en = 0;
  logic [NWE-1:0] exp_wen = '0;
  logic [AW-1:0]  exp_addr = '0;
  logic [DW-1:0]  exp_dout = '0;
  logic [DW-1:0]  exp_rdata0 = '0, exp_rdata1 = '0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  bit  m_last = 1;
  bit  exp_gseq [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
  int  m_hold = 0;
  bit  exp_gseq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

  function automatic cmd_t mk(input bit v, input logic [NWE-1:0] we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    cmd_t c;
    c.vld = v; c.we = we; c.addr = a; c.wdata = d;
    return c;
  endfunction

  // Driver: present the queue front, retire it once accepted (or once a bubble was shown).
  always @(posedge clk) begin
    #1;
    if (shown0 && q0.size() > 0 && (!q0[0].vld || acc0)) void'(q0.pop_front());
    if (shown1 && q1.size() > 0 && (!q1[0].vld || acc1)) void'(q1.pop_front());
    if (q0.size() > 0) begin
      req0_valid = q0[0].vld; req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
      shown0 = 1;
    end else begin
      req0_valid = 1'b0; shown0 = 0;
    end
    if (q1.size() > 0) begin
      req1_valid = q1[0].vld; req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
      shown1 = 1;
    end else begin
      req1_valid = 1'b0; shown1 = 0;
    end
  end

  // Monitor + reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    bit             g0, g1, e0, e1;
    resp_t          r;
    logic [NWE-1:0] t_we;
    logic [AW-1:0]  t_addr;
    logic [DW-1:0]  t_wdata;
    int             idx;
    cyc++;
    rv0_cnt += int'(req0_rvalid);
    rv1_cnt += int'(req1_rvalid);
    if (!rst_n) begin
      check_eq("rst_bram_en", bram_en, 0);
      check_eq("rst_bram_wen", bram_wen, 0);
      check_eq("rst_bram_addr", bram_addr, 0);
      check_eq("rst_bram_dout", bram_dout, 0);
      check_eq("rst_rvalid0", req0_rvalid, 0);
      check_eq("rst_rvalid1", req1_rvalid, 0);
      check_eq("rst_rdata0", req0_rdata, 0);
      check_eq("rst_rdata1", req1_rdata, 0);
      check_eq("rst_ready0", req0_ready, 0);
      check_eq("rst_ready1", req1_ready, 0);
      exp_en = 0; exp_wen = '0; exp_addr = '0; exp_dout = '0;
      exp_rdata0 = '0; exp_rdata1 = '0;
      resp_q.delete();
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      m_last = 1;
`else
      m_hold = 0;
`endif
      acc0 = 0; acc1 = 0;
    end else begin
      check_eq("bram_en", bram_en, exp_en);
      check_eq("bram_wen", bram_wen, exp_wen);
      check_eq("bram_addr", bram_addr, exp_addr);
      check_eq("bram_dout", bram_dout, exp_dout);

      e0 = 0; e1 = 0;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        r = resp_q.pop_front();
        if (r.owner == 0) begin e0 = 1; exp_rdata0 = r.data; end
        else              begin e1 = 1; exp_rdata1 = r.data; end
      end
      check_eq("rvalid0", req0_rvalid, e0);
      check_eq("rvalid1", req1_rvalid, e1);
      check_eq("rdata0", req0_rdata, exp_rdata0);
      check_eq("rdata1", req1_rdata, exp_rdata1);

      if (req0_valid && req1_valid) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        g1 = (m_last == 0);
`else
        g1 = (m_hold >= MAX_HOLD);
`endif
        g0 = !g1;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      check_eq("ready0", req0_ready, g0);
      check_eq("ready1", req1_ready, g1);
      acc0 = g0; acc1 = g1;
      if (rec_en && req0_valid && req0_ready) gseq.push_back(0);
      if (rec_en && req1_valid && req1_ready) gseq.push_back(1);

`ifdef BRAM_ARB_ROUND_ROBIN_EN
      if (g0) m_last = 0;
      else if (g1) m_last = 1;
`else
      if (g1 || !req1_valid) m_hold = 0;
      else if (g0 && m_hold < MAX_HOLD) m_hold++;
`endif

      if (g0 || g1) begin
        t_we    = g0 ? req0_we : req1_we;
        t_addr  = g0 ? req0_addr : req1_addr;
        t_wdata = g0 ? req0_wdata : req1_wdata;
        idx     = int'(t_addr[5:2]);
        exp_en = 1; exp_wen = t_we; exp_addr = t_addr; exp_dout = t_wdata;
        if (t_we == '0) begin
          resp_q.push_back('{cyc + 3, g1, ref_mem[idx]});
        end else begin
          for (int b = 0; b < NWE; b++) begin
            if (t_we[b]) ref_mem[idx][b*8 +: 8] = t_wdata[b*8 +: 8];
          end
        end
      end else begin
        exp_en = 0; exp_wen = '0;
      end
    end
  end

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #2;
      if (q0.size() == 0 && q1.size() == 0 && resp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    check_eq(tag, done, 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  initial begin
    int s0, s1;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      bram_mem[i] = $urandom;
      ref_mem[i]  = bram_mem[i];
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #2;

    // Contention grant pattern from a clean reset.
    gseq.delete();
    rec_en = 1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(1, 4'h0, 32'h0, 32'h0));
      q1.push_back(mk(1, 4'h0, 32'h4, 32'h0));
    end
    for (int i = 0; i < 60 && gseq.size() < 10; i++) begin
      @(negedge clk); #2;
    end
    rec_en = 0;
    check_eq("grant_count", gseq.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gseq.size(); i++) check_eq($sformatf("grant_seq[%0d]", i), gseq[i], exp_gseq[i]);
    wait_drain("drain_grant");

    // Full-word write then read by requester 0 only.
    s0 = rv0_cnt; s1 = rv1_cnt;
    q0.push_back(mk(1, 4'hF, 32'h10, 32'hDEADBEEF));
    q0.push_back(mk(1, 4'h0, 32'h10, 32'h0));
    wait_drain("drain_single");
    check_eq("single_rdata0", req0_rdata, 32'hDEADBEEF);
    check_eq("single_rv0_pulses", rv0_cnt - s0, 1);
    check_eq("single_rv1_pulses", rv1_cnt - s1, 0);

    // Byte write by requester 1 over a preloaded word.
    q1.push_back(mk(1, 4'hF, 32'h20, 32'h11223344));
    q1.push_back(mk(1, 4'h1, 32'h20, 32'h000000AA));
    q1.push_back(mk(1, 4'h0, 32'h20, 32'h0));
    wait_drain("drain_byte");
    check_eq("byte_rdata1", req1_rdata, 32'h112233AA);

    // Idle gap between a write and a read.
    s0 = rv0_cnt; s1 = rv1_cnt;
    q0.push_back(mk(1, 4'hF, 32'h30, 32'hCAFEF00D));
    for (int i = 0; i < 3; i++) q0.push_back(mk(0, 4'h0, 32'h0, 32'h0));
    q0.push_back(mk(1, 4'h0, 32'h30, 32'h0));
    wait_drain("drain_gap");
    check_eq("gap_rdata0", req0_rdata, 32'hCAFEF00D);
    check_eq("gap_rv_pulses", (rv0_cnt - s0) + (rv1_cnt - s1), 1);

    // Randomized traffic from both requesters.
    for (int i = 0; i < 80; i++) begin
      q0.push_back(mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'(($urandom)) : 4'h0,
                      {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom));
      q1.push_back(mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'(($urandom)) : 4'h0,
                      {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom));
    end
    wait_drain("drain_random");

    // Reset one cycle after a read is accepted: the read must never return.
    s0 = rv0_cnt; s1 = rv1_cnt;
    q0.push_back(mk(1, 4'h0, 32'h10, 32'h0));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (acc0) begin ok = 1; break; end
    end
    check_eq("rst_read_accepted", ok, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    check_eq("rst_no_rv0", rv0_cnt - s0, 0);
    check_eq("rst_no_rv1", rv1_cnt - s1, 0);

    // Traffic resumes normally after the mid-run reset.
    q0.push_back(mk(1, 4'h0, 32'h10, 32'h0));
    wait_drain("drain_post_rst");
    check_eq("post_rst_rdata0", req0_rdata, ref_mem[4]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the MicroBlaze local-memory BRAM block between two requesters: requester 0 (accelerator/VNF datapath, high priority) and requester 1 (debug/DMA loader).
- Drives the BRAM-side signal set (EN, WEN, Addr, Dout = write data, Din = read data).
- Issues at most one access per cycle, pipelines commands to BRAM, and routes read data back to the owning requester with a fixed latency.
- Sits between the requester interfaces and the port-B inputs of the BRAM block wrapper.

Parameters:
- C_PORT_AWIDTH, 32, address width of requests and BRAM_Addr.
- C_PORT_DWIDTH, 32, data width; must be a multiple of 8.
- C_NUM_WE, 4, byte write enables; equals C_PORT_DWIDTH/8.
- C_MAX_HOLD, 4, maximum consecutive grants to requester 0 while requester 1 is waiting; range 1..15.

Ports:
- BRAM_Clk  in  1  single clock; all logic is rising-edge.
- BRAM_Rst_N  in  1  asynchronous active-low reset.
- Req0_Valid  in  1  requester 0 command valid.
- Req0_Ready  out  1  requester 0 command accepted this cycle.
- Req0_WE  in  C_NUM_WE  byte write enables; all-zero means read.
- Req0_Addr  in  C_PORT_AWIDTH  byte address.
- Req0_WData  in  C_PORT_DWIDTH  write data.
- Req0_RValid  out  1  read data valid pulse.
- Req0_RData  out  C_PORT_DWIDTH  read data.
- Req1_Valid, Req1_Ready, Req1_WE, Req1_Addr, Req1_WData, Req1_RValid, Req1_RData: same as the requester 0 set, for requester 1.
- BRAM_EN  out  1  BRAM port enable.
- BRAM_WEN  out  C_NUM_WE  BRAM byte write enables.
- BRAM_Addr  out  C_PORT_AWIDTH  BRAM address.
- BRAM_Dout  out  C_PORT_DWIDTH  write data to BRAM.
- BRAM_Din  in  C_PORT_DWIDTH  read data from BRAM (1-cycle read latency).

Behaviour:
Reset values:
- On BRAM_Rst_N low (asserted asynchronously, released synchronously by the upstream reset bridge):
  - BRAM_EN=0, BRAM_WEN=0, BRAM_Addr=0, BRAM_Dout=0.
  - Req*_RValid=0, Req*_RData=0.
  - Hold counter=0, last-grant=1, read pipeline flushed.
- Req*_Ready is combinational and low while reset is asserted.
- Reset mid-operation discards in-flight reads; no RValid pulse follows.

Arbitration (evaluated every cycle, combinational):
- Only Req0 valid: grant 0.
- Only Req1 valid: grant 1.
- Both valid: grant 0 unless hold counter == C_MAX_HOLD, then grant 1.
- Neither valid: no grant.
- Ready is asserted only for the granted requester. Accept = Valid & Ready.
- A requester must hold Valid and its command stable until accepted.

Hold counter:
- Increments on each grant to requester 0 while Req1_Valid=1, saturating at C_MAX_HOLD.
- Clears to 0 on a grant to requester 1, or when Req1_Valid=0.

Pipeline:
- Accept in cycle T: BRAM_EN=1, WEN/Addr/Dout registered from the winner in cycle T+1.
- No accept: BRAM_EN=0 and WEN=0 in T+1; Addr/Dout hold their previous values.
- Read (WE all-zero): a tag {valid, owner} travels 2 stages. In T+2 BRAM_Din is valid; it is registered into the owner's RData, and the owner's RValid pulses 1 cycle in T+3.
- Read latency is exactly 3 cycles from accept. Writes produce no response.
- Back-to-back reads from alternating requesters each return in order, one per cycle.
- RData holds its last value when RValid=0.
- A read and a write to the same address accepted in consecutive cycles follow BRAM write-first semantics; no forwarding.

Optional Feature:
- Macro BRAM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid, grant goes to the requester not granted last (last-grant register). The hold counter and C_MAX_HOLD are unused and removed.
- Undefined: fixed priority with the C_MAX_HOLD starvation guard described above.

Decomposition:
- Package bram_arb_pkg:
  - owner encoding (OWNER_REQ0=0, OWNER_REQ1=1);
  - read-tag struct {valid, owner};
  - localparam READ_LATENCY=3.
- One sub-module, bram_arb_rdpipe: 2-stage tag shift register plus the per-requester RData/RValid registers, with async active-low reset.

Test Plan:
- Reset check: assert BRAM_Rst_N mid-read (read accepted, cycle T+1) -> no RValid on either requester; all outputs 0 while in reset.
- Single requester: Req0 writes 0xDEADBEEF to 0x10 with WE=4'b1111, then reads 0x10 -> BRAM_EN/WEN=1111 in T+1; Req0_RValid pulses in T'+3 with RData=0xDEADBEEF; Req1_RValid stays 0.
- Byte write: Req1 writes 0x000000AA to 0x20 with WE=4'b0001 over preloaded 0x11223344 -> a read returns 0x112233AA.
- Starvation guard (macro undefined): both valid continuously -> grant sequence 0,0,0,0,1,0,0,0,0,1 (C_MAX_HOLD=4).
- Round-robin (macro defined): both valid continuously -> grants alternate 0,1,0,1; reads to 0x0/0x4 return to the correct owners in order, one per cycle.
- Idle gap: valids drop for 3 cycles -> BRAM_EN=0 and BRAM_WEN=0 in the corresponding cycles; no spurious RValid.
